gpr_wb_sched: RTL and testbench
===============================

# gpr_wb_sched

Writeback scheduler and scoreboard for the 32×32 general-purpose register file. It shares the file's single write port between NREQ execution units with per-unit valid/ready handshakes and round-robin fairness. It tracks pending destination registers in a busy scoreboard and stalls the issue stage on RAW/WAW hazards. It sits between the execution units and the register file's `wbe`/`rdn`/`rdd` write inputs.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rstn_h  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i has a result
- req_rdn  in  NREQ×5  destination register of requester i
- req_rdd  in  NREQ×XLEN  result data of requester i
- req_ready  out  NREQ  one-hot grant; result i is consumed at this edge
- iss_valid  in  1  issue stage presents an instruction
- iss_rdn  in  5  destination register of the issuing instruction
- iss_rs1n, iss_rs2n  in  5 each  source registers of the issuing instruction
- iss_stall  out  1  issue must hold; the instruction is not accepted
- wbe  out  1  register-file write enable
- rdn  out  5  register-file write address
- rdd  out  XLEN  register-file write data
- busy  out  32  scoreboard bit vector; bit 0 is always 0

## Operation
- **Arbiter**
  - Round-robin over `req_valid`, starting at pointer `ptr`.
  - Grant goes to the first valid index at or after `ptr`, wrapping.
  - `req_ready` is combinational from `req_valid` and `ptr`. At most one bit is set. It is zero when no request is valid.
  - On a grant to index g, `ptr` becomes (g+1) mod NREQ. Without a grant, `ptr` holds.
  - Requesters keep valid, rdn and rdd stable until ready. A dropped valid before ready is a protocol error; the behaviour is undefined.
- **Write stage**
  - The granted rdn/rdd are registered into `rdn`/`rdd` at the edge.
  - `wbe` is registered to 1 at that edge only if the granted rdn ≠ 0.
  - Writes to x0 are consumed (ready=1) but never produce `wbe`.
  - Without a grant, `wbe` is registered to 0. `rdn`/`rdd` may hold their old values.
- **Scoreboard**
  - Set: `busy[iss_rdn]` is set when `iss_valid && !iss_stall && iss_rdn≠0`.
  - Clear: `busy[rdn]` is cleared on the edge where `wbe=1`.
  - Same register set and cleared in one cycle: set wins, because a new writer is pending.
  - Each busy register is assumed to have exactly one pending writer. This is enforced by the WAW stall.
- **Stall**
  - `iss_stall = iss_valid && (busy[iss_rs1n] || busy[iss_rs2n] || busy[iss_rdn])`.
  - Uses registered busy only. There is no bypass of the in-flight `wbe` write, because the register file's read returns the old value during that cycle.
  - x0 sources never stall.

## Timing
- **Reset values:** `wbe`=0, `rdn`=0, `rdd`=0, `busy`=0, `ptr`=0.
  - `req_ready` and `iss_stall` are 0 while `rstn_h`=0.
  - Reset asserted mid-operation drops any pending grant or write. Un-written results are lost, and their busy bits are cleared.
- **Grant to write latency:** 1 cycle.
  - Result accepted at edge N gives `wbe`/`rdn`/`rdd` valid in cycle N→N+1.
  - The register file writes at edge N+1, and busy clears at edge N+1.
- **Issue to readable:** a dependent instruction unstalls in the cycle after the clearing edge. Its asynchronous read then returns the new value.
- **Throughput:** one write per cycle sustained. No buffering; backpressure to requesters is purely via `req_ready`.
- **Same-cycle events:** an issue setting register r and a writeback clearing a different register s proceed independently.

## Structure
- Package `gpr_ctrl_pkg` holds:
  - `NREG`=32, `REG_AW`=5, `XLEN`
  - `reg_addr_t`
  - `wb_req_t` struct {rdn, rdd}
- Sub-module `rr_arbiter` (parameter N): inputs req and advance; outputs one-hot gnt; owns `ptr`.
- Scoreboard, write-stage registers and stall logic live in `gpr_wb_sched`.

## Test plan
- Reset: hold `rstn_h`=0 with all `req_valid`=1 → `req_ready`=0, `wbe`=0, `busy`=0. Release → first grant is to index 0.
- Round-robin: all three valid continuously for 6 cycles → grants 0,1,2,0,1,2 and `wbe` each cycle with matching rdn/rdd one cycle later.
- RAW stall:
  - Issue rd=5 → `busy[5]`=1.
  - Next issue with rs1=5 → `iss_stall`=1.
  - Requester 1 returns rdn=5, rdd=0xDEADBEEF at edge N → `wbe`=1 during N→N+1, `busy[5]` clears at N+1, stall drops in cycle N+1.
- x0 write: requester 2 valid with rdn=0 → `req_ready[2]`=1, `wbe` stays 0, `busy` unchanged.
- Set/clear collision: writeback of x7 (`wbe`=1, rdn=7) in the same cycle as an issue with rd=7 that does not stall → `busy[7]`=1 afterward.
- Mid-operation reset: `busy`=0x0000_00F0 with a grant pending; pulse `rstn_h` low asynchronously → `busy`=0, `wbe`=0 immediately, `ptr`=0.

Source files
------------

// File: rtl/gpr_ctrl_pkg.sv
// Shared types and constants for the general-purpose register file control path.
package gpr_ctrl_pkg;

    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned XLEN   = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rdn;
        logic [XLEN-1:0] rdd;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping.
module rr_arbiter
    import gpr_ctrl_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rstn_h,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic          found;

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        idx   = '0;
        sum   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            // modular index without a divider: ptr + k < 2N always
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gidx     = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gidx == LAST) ? '0 : gidx + PW'(1);
        end
    end

endmodule

// File: rtl/gpr_wb_sched.sv
// Writeback scheduler and busy scoreboard in front of the 32x32 register file write port.
module gpr_wb_sched #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 32
) (
    input  logic                                  clk,
    input  logic                                  rstn_h,
    input  logic [NREQ-1:0]                       req_valid,
    input  logic [NREQ*gpr_ctrl_pkg::REG_AW-1:0]  req_rdn,
    input  logic [NREQ*XLEN-1:0]                  req_rdd,
    output logic [NREQ-1:0]                       req_ready,
    input  logic                                  iss_valid,
    input  logic [gpr_ctrl_pkg::REG_AW-1:0]       iss_rdn,
    input  logic [gpr_ctrl_pkg::REG_AW-1:0]       iss_rs1n,
    input  logic [gpr_ctrl_pkg::REG_AW-1:0]       iss_rs2n,
    output logic                                  iss_stall,
    output logic                                  wbe,
    output logic [gpr_ctrl_pkg::REG_AW-1:0]       rdn,
    output logic [XLEN-1:0]                       rdd,
    output logic [gpr_ctrl_pkg::NREG-1:0]         busy
);

    import gpr_ctrl_pkg::*;

    logic [NREQ-1:0] req_gated;
    logic [NREQ-1:0] gnt;
    logic            any_gnt;
    reg_addr_t       g_rdn;
    logic [XLEN-1:0] g_rdd;
    logic            iss_fire;
    logic [NREG-1:0] busy_n;

    // Masking requests during reset keeps req_ready low while rstn_h is low.
    assign req_gated = rstn_h ? req_valid : '0;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rstn_h  (rstn_h),
        .req     (req_gated),
        .advance (1'b1),
        .gnt     (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    always_comb begin
        g_rdn = '0;
        g_rdd = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                g_rdn = g_rdn | req_rdn[i*REG_AW +: REG_AW];
                g_rdd = g_rdd | req_rdd[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
            wbe <= 1'b0;
            rdn <= '0;
            rdd <= '0;
        end else begin
            wbe <= any_gnt && (g_rdn != '0);
            if (any_gnt) begin
                rdn <= g_rdn;
                rdd <= g_rdd;
            end
        end
    end

    // Registered busy only: the in-flight write is not yet readable from the file.
    assign iss_stall = rstn_h && iss_valid &&
                       (busy[iss_rs1n] || busy[iss_rs2n] || busy[iss_rdn]);
    assign iss_fire  = iss_valid && !iss_stall && (iss_rdn != '0);

    always_comb begin
        busy_n = busy;
        if (wbe) begin
            busy_n[rdn] = 1'b0;
        end
        if (iss_fire) begin
            busy_n[iss_rdn] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
            busy <= '0;
        end else begin
            busy <= busy_n;
        end
    end

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Self-checking bench for gpr_wb_sched against a behavioural writeback/scoreboard model.
module tb_gpr_wb_sched;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic        clk;
    logic        rstn_h;
    logic [2:0]  req_valid;
    logic [14:0] req_rdn;
    logic [95:0] req_rdd;
    logic [2:0]  req_ready;
    logic        iss_valid;
    logic [4:0]  iss_rdn, iss_rs1n, iss_rs2n;
    logic        iss_stall;
    logic        wbe;
    logic [4:0]  rdn;
    logic [31:0] rdd;
    logic [31:0] busy;

    int tests = 0;
    int fails = 0;

    // model state
    int          m_ptr;
    logic [31:0] m_busy;
    logic        m_wbe;
    logic [4:0]  m_rdn;
    logic [31:0] m_rdd;

    gpr_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rstn_h    (rstn_h),
        .req_valid (req_valid),
        .req_rdn   (req_rdn),
        .req_rdd   (req_rdd),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_rdn   (iss_rdn),
        .iss_rs1n  (iss_rs1n),
        .iss_rs2n  (iss_rs2n),
        .iss_stall (iss_stall),
        .wbe       (wbe),
        .rdn       (rdn),
        .rdd       (rdd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [2:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [2:0] exp_ready();
        logic [2:0] r;
        int g;
        r = '0;
        g = pick(req_valid, m_ptr);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_stall();
        return iss_valid && (m_busy[iss_rs1n] || m_busy[iss_rs2n] || m_busy[iss_rdn]);
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_wbe  = 1'b0;
        m_rdn  = '0;
        m_rdd  = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]      = v;
        req_rdn[i*5 +: 5] = a;
        req_rdd[i*32 +: 32] = d;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_rdn   = '0;
        req_rdd   = '0;
        iss_valid = 1'b0;
        iss_rdn   = '0;
        iss_rs1n  = '0;
        iss_rs2n  = '0;
    endtask

    // Advance one clock edge, updating the model from the inputs presented in this cycle.
    task automatic tick();
        int g;
        logic [31:0] nb;
        g  = pick(req_valid, m_ptr);
        nb = m_busy;
        if (m_wbe) nb[m_rdn] = 1'b0;
        if (iss_valid && !exp_stall() && iss_rdn != 0) nb[iss_rdn] = 1'b1;
        nb[0] = 1'b0;
        @(posedge clk);
        m_busy = nb;
        if (g >= 0) begin
            m_wbe = (req_rdn[g*5 +: 5] != 0);
            m_rdn = req_rdn[g*5 +: 5];
            m_rdd = req_rdd[g*32 +: 32];
            m_ptr = (g + 1) % NREQ;
        end else begin
            m_wbe = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn_h = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rstn_h = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn_h    = 1'b0;
        req_valid = '1;
        iss_valid = 1'b1;
        iss_rs1n  = 5'd3;
        @(negedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready: got %b expected %b", req_ready, 3'b000); end
        tests++; if (wbe !== 1'b0) begin fails++; $display("FAIL reset_wbe: got %b expected 0", wbe); end
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy: got %h expected 0", busy); end
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", iss_stall); end
        tests++; if (rdn !== 5'd0 || rdd !== 32'h0) begin fails++; $display("FAIL reset_rdn_rdd: got %h/%h expected 0/0", rdn, rdd); end
        model_reset();
        rstn_h = 1'b1;
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL reset_first_grant: got %b expected 001", req_ready); end
    endtask

    task automatic test_round_robin();
        int seq[6] = '{0, 1, 2, 0, 1, 2};
        logic [2:0] er;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h1111_1111 * (i + 1));
        for (int c = 0; c < 6; c++) begin
            #1;
            er = 3'(1 << seq[c]);
            tests++; if (req_ready !== er) begin fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, er); end
            tick();
            tests++;
            if (wbe !== 1'b1 || rdn !== 5'(seq[c] + 1) || rdd !== 32'h1111_1111 * (seq[c] + 1)) begin
                fails++;
                $display("FAIL rr_write[%0d]: got wbe=%b rdn=%0d rdd=%h expected wbe=1 rdn=%0d rdd=%h",
                         c, wbe, rdn, rdd, seq[c] + 1, 32'h1111_1111 * (seq[c] + 1));
            end
        end
    endtask

    task automatic test_raw_stall();
        do_reset();
        iss_valid = 1'b1; iss_rdn = 5'd5; iss_rs1n = 5'd0; iss_rs2n = 5'd0;
        tick();
        tests++; if (busy !== 32'h20) begin fails++; $display("FAIL raw_set: got %h expected 00000020", busy); end
        iss_rdn = 5'd9; iss_rs1n = 5'd5;
        #1;
        tests++; if (iss_stall !== 1'b1) begin fails++; $display("FAIL raw_stall: got %b expected 1", iss_stall); end
        tick();
        tests++; if (busy !== 32'h20) begin fails++; $display("FAIL raw_held: got %h expected 00000020", busy); end
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL raw_grant: got %b expected 010", req_ready); end
        tick();
        tests++;
        if (wbe !== 1'b1 || rdn !== 5'd5 || rdd !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL raw_write: got wbe=%b rdn=%0d rdd=%h expected 1/5/deadbeef", wbe, rdn, rdd);
        end
        tests++; if (iss_stall !== 1'b1 || busy !== 32'h20) begin fails++; $display("FAIL raw_no_bypass: got stall=%b busy=%h expected 1/00000020", iss_stall, busy); end
        set_req(1, 1'b0, 5'd0, 32'h0);
        tick();
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL raw_clear: got %h expected 0", busy); end
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL raw_unstall: got %b expected 0", iss_stall); end
        tick();
        tests++; if (busy !== 32'h200) begin fails++; $display("FAIL raw_accept: got %h expected 00000200", busy); end
        iss_valid = 1'b0;
    endtask

    task automatic test_x0_write();
        do_reset();
        iss_valid = 1'b1; iss_rdn = 5'd3;
        tick();
        iss_valid = 1'b0;
        set_req(2, 1'b1, 5'd0, 32'hCAFE_0000);
        #1;
        tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL x0_ready: got %b expected 100", req_ready); end
        tick();
        set_req(2, 1'b0, 5'd0, 32'h0);
        tests++; if (wbe !== 1'b0) begin fails++; $display("FAIL x0_wbe: got %b expected 0", wbe); end
        tests++; if (busy !== 32'h8) begin fails++; $display("FAIL x0_busy: got %h expected 00000008", busy); end
    endtask

    task automatic test_collision();
        do_reset();
        set_req(0, 1'b1, 5'd7, 32'h7777_0007);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        tests++; if (wbe !== 1'b1 || rdn !== 5'd7) begin fails++; $display("FAIL coll_write: got wbe=%b rdn=%0d expected 1/7", wbe, rdn); end
        iss_valid = 1'b1; iss_rdn = 5'd7; iss_rs1n = 5'd0; iss_rs2n = 5'd0;
        #1;
        tests++; if (iss_stall !== 1'b0) begin fails++; $display("FAIL coll_stall: got %b expected 0", iss_stall); end
        tick();
        iss_valid = 1'b0;
        tests++; if (busy !== 32'h80) begin fails++; $display("FAIL coll_busy: got %h expected 00000080", busy); end
    endtask

    task automatic test_random();
        logic [2:0] er;
        logic [2:0] last;
        do_reset();
        last = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last[i]) begin
                    set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
                end
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rdn   = 5'($urandom_range(0, 7));
            iss_rs1n  = 5'($urandom_range(0, 7));
            iss_rs2n  = 5'($urandom_range(0, 7));
            #1;
            er = exp_ready();
            tests++; if (req_ready !== er) begin fails++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, req_ready, er); end
            tests++; if (iss_stall !== exp_stall()) begin fails++; $display("FAIL rnd_stall[%0d]: got %b expected %b", c, iss_stall, exp_stall()); end
            last = er;
            tick();
            tests++; if (wbe !== m_wbe) begin fails++; $display("FAIL rnd_wbe[%0d]: got %b expected %b", c, wbe, m_wbe); end
            if (m_wbe) begin
                tests++; if (rdn !== m_rdn || rdd !== m_rdd) begin fails++; $display("FAIL rnd_data[%0d]: got %0d/%h expected %0d/%h", c, rdn, rdd, m_rdn, m_rdd); end
            end
            tests++; if (busy !== m_busy) begin fails++; $display("FAIL rnd_busy[%0d]: got %h expected %h", c, busy, m_busy); end
        end
        clear_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int r = 4; r < 8; r++) begin
            iss_valid = 1'b1; iss_rdn = 5'(r); iss_rs1n = 5'd0; iss_rs2n = 5'd0;
            tick();
        end
        iss_valid = 1'b0;
        tests++; if (busy !== 32'hF0) begin fails++; $display("FAIL mid_setup: got %h expected 000000f0", busy); end
        set_req(0, 1'b1, 5'd4, 32'h4444_4444);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 5'd5, 32'h5555_5555);
        tests++; if (wbe !== 1'b1) begin fails++; $display("FAIL mid_pending: got %b expected 1", wbe); end
        #2;
        rstn_h = 1'b0;
        #1;
        tests++; if (busy !== 32'h0 || wbe !== 1'b0) begin fails++; $display("FAIL mid_async: got busy=%h wbe=%b expected 0/0", busy, wbe); end
        tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL mid_ready: got %b expected 000", req_ready); end
        @(negedge clk);
        model_reset();
        req_valid = '1;
        rstn_h = 1'b1;
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL mid_ptr: got %b expected 001", req_ready); end
    endtask

    initial begin
        rstn_h = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_raw_stall();
        test_x0_write();
        test_collision();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
